// File: rtl/exc_request_ctrl.sv
// exc_request_ctrl: initiator side of the exception handshake.
// Latches exception event pulses as pending, picks the lowest-index enabled
// source, offers it to the exception unit on Exc/EStatus and then waits for
// the handler to finish (ERet) before offering anything else. No nesting.
//
// Optional build macro: EXC_ACK_TIMEOUT_EN
//   Defined   : an ACK watchdog drops an unanswered request after exactly
//               ACK_TIMEOUT cycles of Exc, keeps the source pending for retry
//               and raises the sticky ack_timeout flag.
//   Undefined : no watchdog; REQ waits for ExcAck indefinitely and
//               ack_timeout is constant 0.
//
// Handshake: Exc acts as a valid that rises one cycle after an eligible event
// is seen and then stays high with a stable EStatus until ExcAck is sampled
// high (ExcAck acts as ready; the transfer happens on the clock edge where
// Exc and ExcAck are both 1). ERet closes the service window that follows.
module exc_request_ctrl #(
    parameter int NSRC        = 4,
    parameter int ACK_TIMEOUT = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_req,
    input  logic [NSRC-1:0] src_mask,
    input  logic            ExcAck,
    input  logic            ERet,
    output logic            Exc,
    output logic [3:0]      EStatus,
    output logic [NSRC-1:0] pending,
    output logic            busy,
    output logic            ack_timeout,
    output logic [1:0]      state_dbg
);

    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            exc_d;
    logic [3:0]      estatus_d;
    logic [NSRC-1:0] pending_d;
    logic            busy_d;
    logic [IW-1:0]   sel_q, sel_d;
    logic [NSRC-1:0] elig;
    logic [IW-1:0]   pick;

`ifdef EXC_ACK_TIMEOUT_EN
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_d;
`else
    // Watchdog absent: constant 0 for every legal ACK_TIMEOUT (>= 1).
    assign ack_timeout = (ACK_TIMEOUT < 1);
`endif

    assign state_dbg = state_q;

    // Eligible sources (a same-cycle pulse counts) and lowest-index winner.
    always_comb begin
        elig = (pending | src_req) & src_mask;
        pick = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) pick = IW'(i);
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d   = state_q;
        exc_d     = Exc;
        estatus_d = EStatus;
        sel_d     = sel_q;
        pending_d = pending | src_req;
`ifdef EXC_ACK_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = ack_timeout;
`endif
        case (state_q)
            IDLE: begin
                exc_d     = 1'b0;
                estatus_d = 4'd0;
                if (|elig) begin
                    state_d   = REQ;
                    exc_d     = 1'b1;
                    estatus_d = 4'(pick) + 4'd1;
                    sel_d     = pick;
`ifdef EXC_ACK_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            REQ: begin
                if (ExcAck) begin
                    state_d = SERVICE;
                    exc_d   = 1'b0;
                    // Acknowledge clears the latched source; a new pulse on
                    // the same source in this cycle keeps it pending.
                    pending_d[sel_q] = src_req[sel_q];
                end
`ifdef EXC_ACK_TIMEOUT_EN
                else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    // Give up on this offer; the source stays pending.
                    state_d   = IDLE;
                    exc_d     = 1'b0;
                    estatus_d = 4'd0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            SERVICE: begin
                exc_d = 1'b0;
                if (ERet) begin
                    state_d   = IDLE;
                    estatus_d = 4'd0;
                end
            end
            default: begin
                state_d   = IDLE;
                exc_d     = 1'b0;
                estatus_d = 4'd0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            Exc     <= 1'b0;
            EStatus <= 4'd0;
            pending <= '0;
            busy    <= 1'b0;
            sel_q   <= '0;
`ifdef EXC_ACK_TIMEOUT_EN
            cnt_q       <= '0;
            ack_timeout <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            Exc     <= exc_d;
            EStatus <= estatus_d;
            pending <= pending_d;
            busy    <= busy_d;
            sel_q   <= sel_d;
`ifdef EXC_ACK_TIMEOUT_EN
            cnt_q       <= cnt_d;
            ack_timeout <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_exc_request_ctrl.sv
// Bench for exc_request_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural
// model plus a scoreboard of offered EStatus codes.
module tb_exc_request_ctrl;

    localparam int NSRC        = 4;
    localparam int ACK_TIMEOUT = 4;
    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_SVC  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] src_req;
    logic [NSRC-1:0] src_mask;
    logic            ExcAck;
    logic            ERet;
    logic            Exc;
    logic [3:0]      EStatus;
    logic [NSRC-1:0] pending;
    logic            busy;
    logic            ack_timeout;
    logic [1:0]      state_dbg;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    logic exc_prev = 1'b0;
    logic [3:0] exp_q[$];

    // Behavioural model state
    int              m_phase = PH_IDLE;
    logic [NSRC-1:0] m_pend  = '0;
    int              m_code  = 0;
    int              m_age   = 0;
    bit              m_tflag = 1'b0;
    logic [NSRC-1:0] m_elig;
    logic [NSRC-1:0] m_next;

    exc_request_ctrl #(.NSRC(NSRC), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_req    (src_req),
        .src_mask   (src_mask),
        .ExcAck     (ExcAck),
        .ERet       (ERet),
        .Exc        (Exc),
        .EStatus    (EStatus),
        .pending    (pending),
        .busy       (busy),
        .ack_timeout(ack_timeout),
        .state_dbg  (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n clock edges; inputs change 1 time unit after the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [NSRC-1:0] r);
        src_req = r;
        cyc(1);
        src_req = '0;
    endtask

    task automatic do_ack();
        ExcAck = 1'b1;
        cyc(1);
        ExcAck = 1'b0;
    endtask

    task automatic do_eret();
        ERet = 1'b1;
        cyc(1);
        ERet = 1'b0;
    endtask

    // Behavioural model: one offer at a time, lowest eligible index wins.
    always @(posedge clk) begin
        if (reset) begin
            m_phase = PH_IDLE;
            m_pend  = '0;
            m_code  = 0;
            m_age   = 0;
            m_tflag = 1'b0;
        end else begin
            m_elig = (m_pend | src_req) & src_mask;
            m_next = m_pend | src_req;
            case (m_phase)
                PH_IDLE: begin
                    if (m_elig != 0) begin
                        for (int i = NSRC - 1; i >= 0; i--)
                            if (m_elig[i]) m_code = i + 1;
                        m_phase = PH_REQ;
                        m_age   = 0;
                        exp_q.push_back(4'(m_code));
                    end
                end
                PH_REQ: begin
                    if (ExcAck) begin
                        if (!src_req[m_code-1]) m_next[m_code-1] = 1'b0;
                        m_phase = PH_SVC;
                    end
`ifdef EXC_ACK_TIMEOUT_EN
                    else begin
                        m_age++;
                        if (m_age == ACK_TIMEOUT) begin
                            m_phase = PH_IDLE;
                            m_code  = 0;
                            m_tflag = 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    if (ERet) begin
                        m_phase = PH_IDLE;
                        m_code  = 0;
                    end
                end
            endcase
            m_pend = m_next;
        end
    end

    // Compare process and scoreboard, on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_exc", Exc, 32'(m_phase == PH_REQ));
            check("model_estatus", EStatus, 32'(m_code));
            check("model_pending", pending, 32'(m_pend));
            check("model_busy", busy, 32'(m_phase != PH_IDLE));
            check("model_ack_timeout", ack_timeout, 32'(m_tflag));
            if (Exc && !exc_prev) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_exc", 32'(EStatus), 32'hFFFF_FFFF);
                end else begin
                    check("sb_offer_code", EStatus, exp_q.pop_front());
                end
            end
            exc_prev = Exc;
        end
    end

    initial begin
        int hi;
        reset    = 1'b1;
        src_req  = '0;
        src_mask = 4'hF;
        ExcAck   = 1'b0;
        ERet     = 1'b0;
        cyc(2);
        chk_en = 1'b1;
        check("rst_exc", Exc, 0);
        check("rst_estatus", EStatus, 0);
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 0);
        check("rst_ack_timeout", ack_timeout, 0);
        reset = 1'b0;
        cyc(1);

        // Single pulse on source 1
        pulse_req(4'b0010);
        check("t1_exc", Exc, 1);
        check("t1_estatus", EStatus, 4'h2);
        check("t1_pending", pending, 4'b0010);
        check("t1_busy", busy, 1);
        do_ack();
        check("t1_ack_exc", Exc, 0);
        check("t1_ack_estatus", EStatus, 4'h2);
        check("t1_ack_pending", pending, 4'b0000);
        do_eret();
        check("t1_eret_busy", busy, 0);
        check("t1_eret_estatus", EStatus, 0);

        // Two sources together: priority, then retry after one bubble
        pulse_req(4'b1010);
        check("t2_estatus", EStatus, 4'h2);
        check("t2_pending", pending, 4'b1010);
        do_ack();
        do_eret();
        check("t2_bubble_exc", Exc, 0);
        cyc(1);
        check("t2_second_exc", Exc, 1);
        check("t2_second_estatus", EStatus, 4'h4);
        do_ack();
        do_eret();

        // ExcAck held 3 cycles with ERet during REQ
        pulse_req(4'b0001);
        ExcAck = 1'b1;
        ERet   = 1'b1;
        cyc(1);
        ERet = 1'b0;
        cyc(2);
        ExcAck = 1'b0;
        check("t3_exc", Exc, 0);
        check("t3_busy", busy, 1);
        check("t3_estatus", EStatus, 4'h1);
        check("t3_pending", pending, 0);
        do_eret();

        // Masked source stays pending until unmasked
        src_mask = 4'b1110;
        pulse_req(4'b0001);
        cyc(3);
        check("t4_masked_exc", Exc, 0);
        check("t4_masked_pending", pending, 4'b0001);
        src_mask = 4'hF;
        cyc(1);
        check("t4_unmask_exc", Exc, 1);
        check("t4_unmask_estatus", EStatus, 4'h1);
        do_ack();
        do_eret();

        // Reset during SERVICE with another source pending
        pulse_req(4'b0001);
        pulse_req(4'b0100);
        do_ack();
        check("t5_svc_pending", pending, 4'b0100);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("t5_rst_exc", Exc, 0);
        check("t5_rst_estatus", EStatus, 0);
        check("t5_rst_pending", pending, 0);
        check("t5_rst_busy", busy, 0);
        cyc(3);
        check("t5_after_exc", Exc, 0);

        // Unanswered request
        pulse_req(4'b0010);
`ifdef EXC_ACK_TIMEOUT_EN
        hi = 1;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            if (Exc) hi++;
            else break;
        end
        check("t6_exc_high_cycles", hi, ACK_TIMEOUT);
        check("t6_ack_timeout", ack_timeout, 1);
        check("t6_drop_estatus", EStatus, 0);
        cyc(1);
        check("t6_retry_exc", Exc, 1);
        check("t6_retry_estatus", EStatus, 4'h2);
`else
        hi = 0;
        cyc(40);
        check("t6_hold_exc", Exc, 1);
        check("t6_hold_estatus", EStatus, 4'h2);
        check("t6_no_timeout", ack_timeout, 0);
`endif
        do_ack();
        do_eret();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < NSRC; b++)
                src_req[b] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0)
                src_mask = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            ExcAck = ($urandom_range(0, 3) == 0);
            ERet   = ($urandom_range(0, 3) == 0);
            cyc(1);
        end
        reset    = 1'b0;
        src_req  = '0;
        ExcAck   = 1'b0;
        ERet     = 1'b0;
        cyc(3);
        check("sb_queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
